// File: rtl/irdy_gen_if.sv
// irdy_gen_if: lock/reset handshake between the ready generator and the domain reset sequencer.
interface irdy_gen_if;
   logic       LOCKED;
   logic       DOMAIN_RST;
   logic       IRDY;
   logic       DOMAIN_UP;
   logic       RST_ERR;
   logic [1:0] ERR_CODE;
   logic [3:0] RETRY_CNT;
   modport master (output LOCKED, DOMAIN_RST, input IRDY, DOMAIN_UP, RST_ERR, ERR_CODE, RETRY_CNT);
   modport slave (input LOCKED, DOMAIN_RST, output IRDY, DOMAIN_UP, RST_ERR, ERR_CODE, RETRY_CNT);
endinterface

// File: rtl/irdy_gen.sv
// irdy_gen: qualifies LOCKED into IRDY and checks the returned DOMAIN_RST pulse width.
// Define IRDY_GEN_AUTORETRY_EN for backoff-and-retry on error; otherwise errors latch into FAULT.
module irdy_gen #(
   parameter int unsigned LOCK_CYCLES = 64,
   parameter int unsigned RST_MIN = 15,
   parameter int unsigned RST_MAX = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned RETRY_GAP = 8
) (
   input logic CLK_generic,
   input logic RST_stimulus,
   irdy_gen_if.slave bus
);
   typedef enum logic [2:0] {WAIT_LOCK, QUALIFY, WAIT_RST, IN_RST, UP, BACKOFF, FAULT} state_t;
`ifdef IRDY_GEN_AUTORETRY_EN
   localparam state_t ERR_NEXT = BACKOFF;
`else
   localparam state_t ERR_NEXT = FAULT;
`endif
   localparam logic [15:0] LOCK_END = 16'(LOCK_CYCLES - 1);
   localparam logic [15:0] TO_END = 16'(TIMEOUT - 1);
   localparam logic [15:0] MAX_END = 16'(RST_MAX - 1);
   localparam logic [15:0] MIN_W = 16'(RST_MIN);
   localparam logic [15:0] GAP_END = 16'(RETRY_GAP - 1);
   state_t state, nxt;
   logic [15:0] cnt, cnt_nxt;
   logic err;
   logic [1:0] code;
   always_comb begin
      nxt = state;
      cnt_nxt = cnt;
      err = 1'b0;
      code = 2'b00;
      case (state)
         WAIT_LOCK: nxt = bus.LOCKED ? QUALIFY : WAIT_LOCK;
         QUALIFY: if (cnt == LOCK_END) nxt = WAIT_RST; else cnt_nxt = cnt + 16'd1;
         WAIT_RST:
            if (bus.DOMAIN_RST) nxt = IN_RST;
            else if (cnt == TO_END) begin err = 1'b1; code = 2'b01; end
            else cnt_nxt = cnt + 16'd1;
         IN_RST:
            if (bus.DOMAIN_RST) begin
               if (cnt == MAX_END) begin err = 1'b1; code = 2'b11; end
               else cnt_nxt = cnt + 16'd1;
            end
            else if (cnt >= MIN_W) nxt = UP;
            else begin err = 1'b1; code = 2'b10; end
         UP: nxt = bus.DOMAIN_RST ? IN_RST : UP;
         BACKOFF: if (cnt == GAP_END) nxt = WAIT_LOCK; else cnt_nxt = cnt + 16'd1;
         default: ;
      endcase
      if (err) nxt = ERR_NEXT;
      // Loss of lock overrides everything, including a pending error.
      if (!bus.LOCKED && state inside {QUALIFY, WAIT_RST, IN_RST, UP}) begin
         nxt = WAIT_LOCK;
         err = 1'b0;
      end
      if (nxt != state) cnt_nxt = (nxt == IN_RST) ? 16'd1 : 16'd0;
   end
   always_ff @(posedge CLK_generic) begin
      if (RST_stimulus) begin
         state <= WAIT_LOCK;
         cnt <= 16'd0;
         bus.RST_ERR <= 1'b0;
         bus.ERR_CODE <= 2'b00;
         bus.RETRY_CNT <= 4'd0;
      end else begin
         state <= nxt;
         cnt <= cnt_nxt;
         if (err) begin
            bus.RST_ERR <= 1'b1;
            bus.ERR_CODE <= code;
         end
         if (state == BACKOFF && nxt == WAIT_LOCK && bus.RETRY_CNT != 4'hF) bus.RETRY_CNT <= bus.RETRY_CNT + 4'd1;
      end
   end
   assign bus.IRDY = state inside {WAIT_RST, IN_RST, UP};
   assign bus.DOMAIN_UP = state == UP;
endmodule

// File: tb/tb_irdy_gen.sv
// tb_irdy_gen: directed vector table plus a cycle-exact lock qualification sequence.
module tb_irdy_gen;
`ifdef IRDY_GEN_AUTORETRY_EN
   localparam logic AR = 1'b1;
`else
   localparam logic AR = 1'b0;
`endif
   typedef struct {
      int n;
      logic rst, lk, dr;
      logic [8:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   vec_t v[$];
   irdy_gen_if bus ();
   irdy_gen dut (.CLK_generic(clk), .RST_stimulus(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t mk(int n, logic r, logic l, logic d, logic ir, logic up, logic er, logic [1:0] cd, logic [3:0] rc);
      vec_t t;
      t.n = n;
      t.rst = r;
      t.lk = l;
      t.dr = d;
      t.exp = {ir, up, er, cd, rc};
      return t;
   endfunction
   function automatic logic [8:0] outs();
      return {bus.IRDY, bus.DOMAIN_UP, bus.RST_ERR, bus.ERR_CODE, bus.RETRY_CNT};
   endfunction
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(string name, logic [8:0] got, logic [8:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b (irdy,up,err,code,retry)", name, got, exp);
      end
   endtask
   initial begin
      bus.LOCKED = 1'b0;
      bus.DOMAIN_RST = 1'b0;
      v.push_back(mk(2, 1, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(5, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(64, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(15, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 1, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(19, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 1, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(30, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(64, 0, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(10, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 0, 0, 1, 2'b10, 4'd0));
      v.push_back(mk(7, 0, 1, 0, 0, 0, 1, 2'b10, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 0, 0, 1, 2'b10, {3'b000, AR}));
      v.push_back(mk(64, 0, 1, 0, 0, 0, 1, 2'b10, {3'b000, AR}));
      v.push_back(mk(1, 0, 1, 0, AR, 0, 1, 2'b10, {3'b000, AR}));
      v.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(31, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 1, 0, 0, 1, 2'b11, 4'd0));
      v.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(254, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 0, 0, 1, 2'b01, 4'd0));
      v.push_back(mk(20, 0, 1, 0, 0, 0, 1, 2'b01, {3'b000, AR}));
      v.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(5, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 1, 1, 1, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(20, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 1, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(31, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 1, 1, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(65, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(14, 0, 1, 1, 1, 0, 0, 2'b00, 4'd0));
      v.push_back(mk(1, 0, 1, 0, 0, 0, 1, 2'b10, 4'd0));
      for (int i = 0; i < v.size(); i++) begin
         rst = v[i].rst;
         bus.LOCKED = v[i].lk;
         bus.DOMAIN_RST = v[i].dr;
         step(v[i].n);
         check($sformatf("vec%0d", i), outs(), v[i].exp);
      end
      // LOCKED rises at edge 10 after reset; IRDY must appear exactly after edge 74.
      begin
         int cyc = 0;
         int rise = -1;
         rst = 1'b1;
         bus.LOCKED = 1'b0;
         bus.DOMAIN_RST = 1'b0;
         step(1);
         rst = 1'b0;
         step(9);
         bus.LOCKED = 1'b1;
         cyc = 9;
         while (rise < 0 && cyc < 200) begin
            step(1);
            cyc++;
            if (bus.IRDY) rise = cyc;
         end
         total++;
         if (rise != 74) begin
            bad++;
            $display("FAIL irdy_rise_edge got=%0d exp=74", rise);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
